uart_tx_core: RTL and testbench

UART_TX_CORE -- requirements
Module: uart_tx

---
 rtl/uart_tx_core.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_core.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - FIFO-fed UART transmitter; optional even parity via UART_TX_PARITY_EN
module uart_tx_core #(
    parameter int WIDTH          = 8,
    parameter int SAMPLING_TICKS = 16,
    parameter int TICK_DIV       = 1,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    output logic             tx,
    output logic             busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = (SAMPLING_TICKS > 1) ? $clog2(SAMPLING_TICKS) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t state;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    logic [DW-1:0]    div_cnt;
    logic [TW-1:0]    tick_cnt;
    logic [BW-1:0]    bit_idx;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             bit_end;
    logic             div_end;
`ifdef UART_TX_PARITY_EN
    logic             parity;
`endif

    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = wr_en && !fifo_full;
    // Launch decision uses registered occupancy, so a same-cycle push into an empty FIFO cannot launch.
    assign pop        = start && (state == IDLE) && !fifo_empty;

    assign div_end    = (div_cnt == DW'(TICK_DIV - 1));
    assign bit_end    = div_end && (tick_cnt == TW'(SAMPLING_TICKS - 1));
    assign shift_next = shift_reg >> 1;

    always_ff @(posedge clk) begin
        if (!rst_n && push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            div_cnt   <= '0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else if (state == IDLE) begin
            tx       <= 1'b1;
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            if (pop) begin
                state     <= START;
                tx        <= 1'b0;
                busy      <= 1'b1;
                shift_reg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                parity    <= ^mem[rd_ptr];
`endif
            end
        end else if (!bit_end) begin
            if (div_end) begin
                div_cnt  <= '0;
                tick_cnt <= tick_cnt + TW'(1);
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end else begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            case (state)
                START: begin
                    state   <= DATA;
                    bit_idx <= '0;
                    tx      <= shift_reg[0];
                end
                DATA: begin
                    if (bit_idx == BW'(WIDTH - 1)) begin
                        bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                        state   <= PARITY;
                        tx      <= parity;
`else
                        state   <= STOP;
                        tx      <= 1'b1;
`endif
                    end else begin
                        bit_idx   <= bit_idx + BW'(1);
                        shift_reg <= shift_next;
                        tx        <= shift_next[0];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    state <= STOP;
                    tx    <= 1'b1;
                end
`endif
                STOP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - self-checking bench for uart_tx_core (honours UART_TX_PARITY_EN)
module tb_uart_tx_core;

    localparam int W      = 8;
    localparam int DEPTH  = 16;
    localparam int BITCLK = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = W + 3;
`else
    localparam int NBITS = W + 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         wr_en = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         start = 1'b0;
    logic         tx;
    logic         busy;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] model_q [$];

    typedef struct {
        logic         rst;
        logic         wr;
        logic [W-1:0] d;
        logic         st;
        logic [1:0]   exp;
    } vec_t;
    vec_t vecs [9];

    always #5 clk = ~clk;

    uart_tx_core #(
        .WIDTH(W), .SAMPLING_TICKS(BITCLK), .TICK_DIV(1), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
        .start(start), .tx(tx), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual{tx,busy}=%b expected{tx,busy}=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_push(input logic [W-1:0] d);
        if (model_q.size() < DEPTH) model_q.push_back(d);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        model_q.delete();
    endtask

    task automatic push(input logic [W-1:0] d);
        wr_en = 1'b1;
        data_in = d;
        tick();
        wr_en = 1'b0;
        model_push(d);
    endtask

    // Frame expectation built from the line protocol: start 0, data LSB first, [even parity], stop 1.
    task automatic expect_frame(input logic [W-1:0] d, input bit noise, input string tag);
        logic bits [NBITS];
        bits[0] = 1'b0;
        for (int j = 0; j < W; j++) bits[j+1] = d[j];
`ifdef UART_TX_PARITY_EN
        bits[W+1] = ^d;
`endif
        bits[NBITS-1] = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NBITS * BITCLK; i++) begin
            check($sformatf("%s_bit%0d_clk%0d", tag, i / BITCLK, i), {tx, busy}, {bits[i / BITCLK], 1'b1});
            if (noise) begin
                start = ($urandom_range(0, 15) == 0);
                wr_en = ($urandom_range(0, 31) == 0);
                data_in = W'($urandom);
                if (wr_en) model_push(data_in);
            end
            tick();
            start = 1'b0;
            wr_en = 1'b0;
        end
        check({tag, "_idle_after"}, {tx, busy}, 2'b10);
    endtask

    task automatic launch(input bit noise, input string tag);
        logic [W-1:0] d;
        if (model_q.size() == 0) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check({tag, "_empty_start"}, {tx, busy}, 2'b10);
        end else begin
            d = model_q.pop_front();
            expect_frame(d, noise, tag);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b10};
        vecs[1] = '{1'b1, 1'b1, 8'h77, 1'b1, 2'b10};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'b10};
        vecs[3] = '{1'b0, 1'b1, 8'hA5, 1'b1, 2'b10};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'b10};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'b01};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'b01};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b10};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'b10};
        for (int i = 0; i < 9; i++) begin
            rst_n = vecs[i].rst;
            wr_en = vecs[i].wr;
            data_in = vecs[i].d;
            start = vecs[i].st;
            tick();
            check($sformatf("vec%0d", i), {tx, busy}, vecs[i].exp);
        end
        rst_n = 1'b0; wr_en = 1'b0; start = 1'b0;
        model_q.delete();

        push(8'hA5);
        launch(1'b0, "a5");
        push(8'h01);
        launch(1'b0, "x01");

        push(8'h3C); push(8'hFF); push(8'h00);
        launch(1'b1, "seq0");
        launch(1'b1, "seq1");
        launch(1'b1, "seq2");
        launch(1'b0, "seq_empty");

        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) push(W'(8'h10 + i));
        for (int i = 0; i <= DEPTH; i++) launch(1'b0, $sformatf("drain%0d", i));

        do_reset();
        push(8'h3C);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (49) tick();
        check("midframe_busy", {tx, busy}, {1'b1, 1'b1} & {tx, 1'b1});
        rst_n = 1'b1;
        wr_en = 1'b1;
        data_in = 8'h99;
        start = 1'b1;
        tick();
        rst_n = 1'b0; wr_en = 1'b0; start = 1'b0;
        model_q.delete();
        check("reset_abort", {tx, busy}, 2'b10);
        launch(1'b0, "post_reset");

        for (int r = 0; r < 25; r++) begin
            int n;
            int k;
            n = $urandom_range(0, 5);
            for (int p = 0; p < n; p++) push(W'($urandom));
            k = $urandom_range(0, 3);
            for (int f = 0; f < k; f++) launch(1'b1, $sformatf("rnd%0d_%0d", r, f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
